// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access stage of the RV64 pipeline. Takes one executed instruction per
// handshake, runs loads/stores on a req/ack data port with byte lanes and load
// sign/zero extension, passes other results through, and emits one registered
// write-back bundle per accepted instruction.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned accesses issue no request and pulse `misalign`
//   undefined : low address bits below the access width are cleared
// -----------------------------------------------------------------------------
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic [63:0] alu_result,
    input  logic [63:0] store_data,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t      r_state;
    state_t      w_next_state;

    // Context of the access in flight, needed when the ack arrives
    logic [2:0]  r_ld_funct3;
    logic [2:0]  r_ld_off;
    logic [4:0]  r_rd;
    logic        r_wb_en;
    logic        r_killed;

    logic        w_accept;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_trap;
    logic        w_ack;
    logic        w_wb_en;
    logic [2:0]  w_keep_mask;
    logic [2:0]  w_off;
    logic [7:0]  w_be;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [63:0] w_rshift;
    logic [63:0] w_load_data;

    // Opcodes whose result is written to the register file
    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0000011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: writes_rd = 1'b1;
            default:                                         writes_rd = 1'b0;
        endcase
    endfunction

    assign in_ready   = (r_state == IDLE);
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_is_load  = (opcode_in == OP_LOAD);
    assign w_is_store = (opcode_in == OP_STORE);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_ack      = (r_state == WAIT) & dmem_req & dmem_ack;
    assign w_wb_en    = (rd_in != 5'd0) & writes_rd(opcode_in);
    assign w_addr     = {alu_result[63:3], w_off};
    assign w_wdata    = store_data << {w_off, 3'b000};
    assign w_rshift   = dmem_rdata >> {r_ld_off, 3'b000};

    // Lane offset, byte enables and alignment check for the incoming access
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch)
        w_keep_mask = 3'b111;
        w_be        = 8'hFF;
        case (funct3_in[1:0])
            2'b00:   w_keep_mask = 3'b111;
            2'b01:   w_keep_mask = 3'b110;
            2'b10:   w_keep_mask = 3'b100;
            default: w_keep_mask = 3'b000;
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        w_off  = alu_result[2:0];
        w_trap = w_is_mem & ((alu_result[2:0] & ~w_keep_mask) != 3'b000);
`else
        w_off  = alu_result[2:0] & w_keep_mask;
        w_trap = 1'b0;
`endif
        case (funct3_in[1:0])
            2'b00:   w_be = 8'h01 << w_off;
            2'b01:   w_be = 8'h03 << w_off;
            2'b10:   w_be = 8'h0F << w_off;
            default: w_be = 8'hFF;
        endcase
    end

    // Extract and extend the loaded value from the returned doubleword
    always_comb begin
        w_load_data = w_rshift;
        case (r_ld_funct3)
            3'b000:  w_load_data = {{56{w_rshift[7]}},  w_rshift[7:0]};
            3'b100:  w_load_data = {56'd0,              w_rshift[7:0]};
            3'b001:  w_load_data = {{48{w_rshift[15]}}, w_rshift[15:0]};
            3'b101:  w_load_data = {48'd0,              w_rshift[15:0]};
            3'b010:  w_load_data = {{32{w_rshift[31]}}, w_rshift[31:0]};
            3'b110:  w_load_data = {32'd0,              w_rshift[31:0]};
            default: w_load_data = w_rshift;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state: enter WAIT on an issued access, leave on the ack edge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept & w_is_mem & ~w_trap) w_next_state = WAIT;
            WAIT:    if (w_ack)                         w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Memory port, write-back bundle and in-flight context registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_be     <= '0;
            wb_valid    <= 1'b0;
            wb_en       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            r_ld_funct3 <= '0;
            r_ld_off    <= '0;
            r_rd        <= '0;
            r_wb_en     <= 1'b0;
            r_killed    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem & ~w_trap) begin
                            dmem_req    <= 1'b1;
                            dmem_we     <= w_is_store;
                            dmem_addr   <= w_addr;
                            dmem_wdata  <= w_wdata;
                            dmem_be     <= w_be;
                            r_ld_funct3 <= funct3_in;
                            r_ld_off    <= w_off;
                            r_rd        <= rd_in;
                            r_wb_en     <= w_wb_en;
                            r_killed    <= 1'b0;
                        end else begin
                            // Pass-through result, or a trapped misaligned access
                            wb_valid <= 1'b1;
                            wb_en    <= w_wb_en & ~w_trap;
                            wb_rd    <= rd_in;
                            wb_data  <= w_trap ? 64'd0 : alu_result;
`ifdef MEM_MISALIGN_TRAP_EN
                            misalign <= w_trap;
`endif
                        end
                    end
                end
                WAIT: begin
                    // The bus cannot be cancelled: a flush only suppresses write-back
                    if (flush) r_killed <= 1'b1;
                    if (w_ack) begin
                        dmem_req <= 1'b0;
                        if (~(r_killed | flush)) begin
                            wb_valid <= 1'b1;
                            wb_en    <= r_wb_en;
                            wb_rd    <= r_rd;
                            wb_data  <= dmem_we ? 64'd0 : w_load_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Scoreboard bench: stimulus pushes expected write-backs and memory requests,
// a memory responder and a write-back monitor pop and compare independently.
// The reference model works on a byte-addressed memory and access sizes.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode_in = '0;
    logic [2:0]  funct3_in = '0;
    logic [4:0]  rd_in = '0;
    logic [63:0] alu_result = '0;
    logic [63:0] store_data = '0;
    logic        flush = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_access_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode_in  (opcode_in),
        .funct3_in  (funct3_in),
        .rd_in      (rd_in),
        .alu_result (alu_result),
        .store_data (store_data),
        .flush      (flush),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign   (misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        int          acc;
        bit          en;
        logic [4:0]  rd;
        logic [63:0] data;
        bit          mis;
    } wb_exp_t;

    typedef struct {
        int          acc;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } req_exp_t;

    wb_exp_t  sb[$];
    req_exp_t rq[$];

    int n_cmp   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ack_cyc = -10;
    int next_lat = 0;
    bit hold_ack = 1'b0;

    logic [7:0]  rmem [logic [63:0]];   // reference model, byte granular
    logic [63:0] bmem [logic [60:0]];   // responder storage, doubleword granular

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ {a[2:0], a[7:3]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [63:0] a);
        if (rmem.exists(a)) return rmem[a];
        return init_byte(a);
    endfunction

    function automatic logic [63:0] bus_rd(input logic [60:0] d);
        logic [63:0] v;
        if (bmem.exists(d)) return bmem[d];
        for (int i = 0; i < 8; i++) v[8*i +: 8] = init_byte({d, 3'(i)});
        return v;
    endfunction

    task automatic bus_wr(input logic [60:0] d, input logic [63:0] wd, input logic [7:0] be);
        logic [63:0] v;
        v = bus_rd(d);
        for (int i = 0; i < 8; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
        bmem[d] = v;
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] dw);
        for (int i = 0; i < 8; i++) rmem[a + 64'(i)] = dw[8*i +: 8];
        bmem[a[63:3]] = dw;
    endtask

    function automatic bit model_wb_en(input logic [6:0] op, input logic [4:0] rd);
        return (rd != 5'd0) && (op inside {7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011,
                                           7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111,
                                           7'b1100111});
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_dmem_req"},   64'(dmem_req),   64'd0);
        check({tag, "_dmem_we"},    64'(dmem_we),    64'd0);
        check({tag, "_dmem_addr"},  dmem_addr,       64'd0);
        check({tag, "_dmem_wdata"}, dmem_wdata,      64'd0);
        check({tag, "_dmem_be"},    64'(dmem_be),    64'd0);
        check({tag, "_wb_valid"},   64'(wb_valid),   64'd0);
        check({tag, "_wb_en"},      64'(wb_en),      64'd0);
        check({tag, "_wb_rd"},      64'(wb_rd),      64'd0);
        check({tag, "_wb_data"},    wb_data,         64'd0);
        check({tag, "_in_ready"},   64'(in_ready),   64'd1);
`ifdef MEM_MISALIGN_TRAP_EN
        check({tag, "_misalign"},   64'(misalign),   64'd0);
`endif
    endtask

    // mode 0: normal, 1: flush while waiting, 2: request abandoned by reset
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] sd, input int mode,
                         output int acc);
        bit          ok;
        bit          is_ld;
        bit          is_st;
        bit          mis;
        int          sz;
        int          off;
        logic [63:0] addr;
        logic [63:0] val;
        logic [63:0] mask;
        wb_exp_t     e;
        req_exp_t    r;
        ok = 1'b0;
        mis = 1'b0;
        opcode_in  = op;
        funct3_in  = f3;
        rd_in      = rd;
        alu_result = alu;
        store_data = sd;
        in_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc   = cyc;
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        sz    = 1 << f3[1:0];
        off   = int'(alu[2:0]);
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (is_ld || is_st) && (off % sz != 0);
`else
        off = off - (off % sz);
`endif
        addr = {alu[63:3], 3'b000} + 64'(off);
        if ((is_ld || is_st) && !mis) begin
            r.acc   = acc;
            r.we    = is_st;
            r.addr  = addr;
            r.wdata = sd << (8 * off);
            r.be    = 8'(((1 << sz) - 1) << off);
            rq.push_back(r);
            val = '0;
            for (int i = 0; i < sz; i++) val[8*i +: 8] = ref_byte(addr + 64'(i));
            mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
            if (!f3[2] && sz < 8 && val[8*sz-1]) val = val | ~mask;
            if (is_st && mode != 2)
                for (int i = 0; i < sz; i++) rmem[addr + 64'(i)] = sd[8*i +: 8];
            if (mode == 0) begin
                e.is_mem = 1'b1;
                e.acc    = acc;
                e.en     = model_wb_en(op, rd);
                e.rd     = rd;
                e.data   = is_ld ? val : 64'd0;
                e.mis    = 1'b0;
                sb.push_back(e);
            end
        end else begin
            e.is_mem = 1'b0;
            e.acc    = acc;
            e.en     = mis ? 1'b0 : model_wb_en(op, rd);
            e.rd     = rd;
            e.data   = alu;
            e.mis    = mis;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (mode == 1 && (is_ld || is_st) && !mis) begin
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
    endtask

    // Present a bundle together with flush while idle: it must vanish
    task automatic drop_flush();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        opcode_in  = OP_ADD;
        rd_in      = 5'd3;
        alu_result = {$urandom, $urandom};
        in_valid   = 1'b1;
        flush      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Memory responder: checks each request against the expectation queue,
    // holds ack for a chosen latency, and sprinkles stray acks while idle
    bit          in_req = 1'b0;
    int          left = 0;
    req_exp_t    cur;
    logic        h_we;
    logic [63:0] h_addr;
    logic [63:0] h_wdata;
    logic [7:0]  h_be;

    always @(negedge clk) begin
        if (reset || !dmem_req) begin
            in_req     = 1'b0;
            dmem_ack   = !reset && ($urandom_range(0, 2) == 0);
            dmem_rdata = {$urandom, $urandom};
        end else begin
            if (!in_req) begin
                h_we = dmem_we; h_addr = dmem_addr; h_wdata = dmem_wdata; h_be = dmem_be;
                if (rq.size() == 0) begin
                    check("unexpected_req", 64'd1, 64'd0);
                    left = 1;
                end else begin
                    cur = rq.pop_front();
                    check("req_cycle", 64'(cyc), 64'(cur.acc + 1));
                    check("req_we",    64'(dmem_we), 64'(cur.we));
                    check("req_addr",  dmem_addr, cur.addr);
                    check("req_be",    64'(dmem_be), 64'(cur.be));
                    if (cur.we) check("req_wdata", dmem_wdata, cur.wdata);
                    left = (next_lat > 0) ? next_lat : $urandom_range(1, 4);
                    next_lat = 0;
                end
                in_req = 1'b1;
            end else begin
                check("req_stable", 64'((dmem_we === h_we) && (dmem_addr === h_addr) &&
                                        (dmem_wdata === h_wdata) && (dmem_be === h_be)), 64'd1);
            end
            check("in_ready_in_wait", 64'(in_ready), 64'd0);
            left--;
            if (left <= 0 && !hold_ack) begin
                dmem_ack   = 1'b1;
                dmem_rdata = bus_rd(dmem_addr[63:3]);
                if (dmem_we) bus_wr(dmem_addr[63:3], dmem_wdata, dmem_be);
                ack_cyc = cyc;
                in_req  = 1'b0;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Write-back monitor
    always @(negedge clk) begin
        wb_exp_t e;
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_wb", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                if (e.is_mem) check("wb_cycle_mem", 64'(cyc), 64'(ack_cyc + 1));
                else          check("wb_cycle_alu", 64'(cyc), 64'(e.acc + 1));
                check("wb_en", 64'(wb_en), 64'(e.en));
                if (e.en) begin
                    check("wb_rd",   64'(wb_rd), 64'(e.rd));
                    check("wb_data", wb_data, e.data);
                end
`ifdef MEM_MISALIGN_TRAP_EN
                check("misalign", 64'(misalign), 64'(e.mis));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, want < 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          a;
        int          kind;
        logic [63:0] addr;
        logic [6:0]  alu_ops [10];
        alu_ops = '{7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0110111,
                    7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011};

        #1;
        check_idle("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ALU pass-through
        issue(OP_ADD, 3'b000, 5'd5, 64'h1234, 64'd0, 0, a);

        // LB from the top byte lane of a word, three request cycles
        preload(64'h1000, 64'h0000_0000_8000_0000);
        next_lat = 3;
        issue(OP_LOAD, 3'b000, 5'd7, 64'h1003, 64'd0, 0, a);

        // SW into the upper word, zero-wait ack
        next_lat = 1;
        issue(OP_STORE, 3'b010, 5'd0, 64'h2004, 64'hDEAD_BEEF, 0, a);

        // LD flushed while waiting, a second flush pulse, then back-to-back ADD
        next_lat = 3;
        issue(OP_LOAD, 3'b011, 5'd9, 64'h1000, 64'd0, 1, a);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        issue(OP_ADD, 3'b000, 5'd10, 64'hABCD, 64'd0, 0, a);
        check("accept_after_ack", 64'(a), 64'(ack_cyc + 1));

        // LW at a half-aligned address
        issue(OP_LOAD, 3'b010, 5'd11, 64'h3002, 64'd0, 0, a);

        // Flush with an incoming bundle while idle
        drop_flush();

        // Reset in the middle of a wait, then a normal LD
        hold_ack = 1'b1;
        issue(OP_LOAD, 3'b011, 5'd12, 64'h1008, 64'd0, 2, a);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("req_before_reset", 64'(dmem_req), 64'd1);
        reset = 1'b1;
        #1;
        check_idle("reset_wait");
        @(negedge clk);
        reset    = 1'b0;
        hold_ack = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        issue(OP_LOAD, 3'b011, 5'd13, 64'h1008, 64'd0, 0, a);

        // Randomized mix
        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) != 0) addr = 64'h1000 + 64'($urandom_range(0, 63));
            else                           addr = {$urandom, $urandom};
            if (kind < 4)
                issue(alu_ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
                      5'($urandom_range(0, 31)), {$urandom, $urandom}, 64'd0, 0, a);
            else if (kind < 7)
                issue(OP_LOAD, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), addr,
                      64'd0, ($urandom_range(0, 7) == 0) ? 1 : 0, a);
            else if (kind < 9)
                issue(OP_STORE, 3'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), addr,
                      {$urandom, $urandom}, ($urandom_range(0, 7) == 0) ? 1 : 0, a);
            else
                drop_flush();
        end

        for (int i = 0; i < 200 && (sb.size() != 0 || rq.size() != 0); i++) @(negedge clk);
        check("drain_empty", 64'(sb.size() + rq.size()), 64'd0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
